skew_fifo_bank: RTL and testbench

SKEW_FIFO_BANK -- requirements
Module: skew_fifo_bank

---
 rtl/skew_fifo_bank_pkg.sv | 18 +
 rtl/fifo_lane.sv | 77 +++++++
 rtl/skew_fifo_bank.sv | 90 +++++++++
 tb/tb_skew_fifo_bank.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/skew_fifo_bank_pkg.sv
// rtl/skew_fifo_bank_pkg.sv - shared lane-slicing constants and types for the PE-array FIFO bank
package skew_fifo_bank_pkg;

  typedef struct packed {
    logic ovf;
    logic unf;
  } lane_err_t;

  // One extra bit so a lane's count can represent DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/fifo_lane.sv
// rtl/fifo_lane.sv - one FIFO lane: storage, pointers, occupancy, flags, registered pop output
module fifo_lane
  import skew_fifo_bank_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int BWIDTH   = 8,
  parameter int AFULL_TH = DEPTH - 2,
  localparam int CW      = cnt_w(DEPTH),
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              push_i,
  input  logic [BWIDTH-1:0] din_i,
  input  logic              pop_i,
  output logic [BWIDTH-1:0] dout_o,
  output logic              valid_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              afull_o,
  output logic [CW-1:0]     count_o,
  output lane_err_t         err_o
);

  logic [BWIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [BWIDTH-1:0] dout_q;
  logic              valid_q;
  logic              do_pop, do_push;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign afull_o = (count_q >= CW'(AFULL_TH));
  assign count_o = count_q;
  assign dout_o  = dout_q;
  assign valid_o = valid_q;

  // A pop frees a slot in the same cycle, so a full lane still accepts a push alongside it.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign err_o.ovf = push_i & ~do_push;
  assign err_o.unf = pop_i & empty_o;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        dout_q   <= mem_q[rd_ptr_q];
      end
      valid_q <= do_pop;
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/skew_fifo_bank.sv
// rtl/skew_fifo_bank.sv - bank of per-lane FIFOs with staggered wavefront pops feeding a PE array
module skew_fifo_bank
  import skew_fifo_bank_pkg::*;
#(
  parameter int NCH      = 32,
  parameter int DEPTH    = 32,
  parameter int BWIDTH   = 8,
  parameter int AFULL_TH = DEPTH - 2,
  parameter int SKEW_EN  = 1
) (
  input  logic                        CLK,
  input  logic                        RSTn,
  input  logic [NCH-1:0]              PUSHE,
  input  logic [NCH*BWIDTH-1:0]       D_in,
  input  logic                        POPE,
  input  logic                        CLR_ERR,
  output logic [NCH*BWIDTH-1:0]       D_out,
  output logic [NCH-1:0]              VALID_out,
  output logic [NCH-1:0]              IS_EMPTY,
  output logic [NCH-1:0]              IS_FULL,
  output logic [NCH-1:0]              ALMOST_FULL,
  output logic [NCH*cnt_w(DEPTH)-1:0] COUNT,
  output logic                        OVF,
  output logic                        UNF
);

  localparam int CW = cnt_w(DEPTH);

  logic [NCH-1:0] lane_pop;
  lane_err_t      lane_err [NCH];
  logic           ovf_ev, unf_ev;
  logic           ovf_q, unf_q;

  // Lane i sees POPE i cycles late, so each wavefront reaches the array as a diagonal.
  if (SKEW_EN != 0 && NCH > 1) begin : g_skew
    logic [NCH-2:0] chain_q;
    always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) chain_q <= '0;
      else       chain_q <= (chain_q << 1) | (NCH-1)'(POPE);
    end
    assign lane_pop = {chain_q, POPE};
  end else begin : g_flat
    assign lane_pop = {NCH{POPE}};
  end

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    fifo_lane #(
      .DEPTH   (DEPTH),
      .BWIDTH  (BWIDTH),
      .AFULL_TH(AFULL_TH)
    ) u_lane (
      .CLK    (CLK),
      .RSTn   (RSTn),
      .push_i (PUSHE[g]),
      .din_i  (D_in[lane_lsb(g, BWIDTH) +: BWIDTH]),
      .pop_i  (lane_pop[g]),
      .dout_o (D_out[lane_lsb(g, BWIDTH) +: BWIDTH]),
      .valid_o(VALID_out[g]),
      .empty_o(IS_EMPTY[g]),
      .full_o (IS_FULL[g]),
      .afull_o(ALMOST_FULL[g]),
      .count_o(COUNT[lane_lsb(g, CW) +: CW]),
      .err_o  (lane_err[g])
    );
  end

  always_comb begin
    ovf_ev = 1'b0;
    unf_ev = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      ovf_ev = ovf_ev | lane_err[k].ovf;
      unf_ev = unf_ev | lane_err[k].unf;
    end
  end

  // A fresh error in the clearing cycle wins over CLR_ERR.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q & ~CLR_ERR) | ovf_ev;
      unf_q <= (unf_q & ~CLR_ERR) | unf_ev;
    end
  end

  assign OVF = ovf_q;
  assign UNF = unf_q;

endmodule

// File: tb/tb_skew_fifo_bank.sv
// tb/tb_skew_fifo_bank.sv - randomized and directed bench for skew_fifo_bank against a queue model
module tb_skew_fifo_bank;

  localparam int NCH = 4;
  localparam int DEPTH = 4;
  localparam int BW = 8;
  localparam int CW = 3;

  logic              CLK = 1'b0;
  logic              RSTn = 1'b0;
  logic [NCH-1:0]    pushe = '0;
  logic [NCH*BW-1:0] din = '0;
  logic              pope = 1'b0;
  logic              clr = 1'b0;

  // index 0: SKEW_EN=1 instance, index 1: SKEW_EN=0 instance
  logic [NCH*BW-1:0] dout [2];
  logic [NCH-1:0]    vout [2];
  logic [NCH-1:0]    empty [2];
  logic [NCH-1:0]    full [2];
  logic [NCH-1:0]    afull [2];
  logic [NCH*CW-1:0] cnt [2];
  logic              ovf [2];
  logic              unf [2];

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  skew_fifo_bank #(.NCH(NCH), .DEPTH(DEPTH), .BWIDTH(BW), .SKEW_EN(1)) u_skew (
    .CLK(CLK), .RSTn(RSTn), .PUSHE(pushe), .D_in(din), .POPE(pope), .CLR_ERR(clr),
    .D_out(dout[0]), .VALID_out(vout[0]), .IS_EMPTY(empty[0]), .IS_FULL(full[0]),
    .ALMOST_FULL(afull[0]), .COUNT(cnt[0]), .OVF(ovf[0]), .UNF(unf[0])
  );

  skew_fifo_bank #(.NCH(NCH), .DEPTH(DEPTH), .BWIDTH(BW), .SKEW_EN(0)) u_flat (
    .CLK(CLK), .RSTn(RSTn), .PUSHE(pushe), .D_in(din), .POPE(pope), .CLR_ERR(clr),
    .D_out(dout[1]), .VALID_out(vout[1]), .IS_EMPTY(empty[1]), .IS_FULL(full[1]),
    .ALMOST_FULL(afull[1]), .COUNT(cnt[1]), .OVF(ovf[1]), .UNF(unf[1])
  );

  // Reference model: per-lane queues plus the list of cycles at which each lane is due to pop.
  logic [BW-1:0] mq [2][NCH][$];
  int            pat [2][NCH][$];
  logic [BW-1:0] m_dout [2][NCH];
  logic          m_valid [2][NCH];
  logic          m_ovf [2];
  logic          m_unf [2];
  int            cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < NCH; i++) begin
        mq[m][i].delete();
        pat[m][i].delete();
        m_dout[m][i] = '0;
        m_valid[m][i] = 1'b0;
      end
      m_ovf[m] = 1'b0;
      m_unf[m] = 1'b0;
    end
  endtask

  task automatic model_step(input logic [NCH-1:0] p, input logic [NCH*BW-1:0] d,
                            input logic po, input logic c);
    for (int m = 0; m < 2; m++) begin
      logic ov, un;
      ov = 1'b0;
      un = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        if (po) pat[m][i].push_back(cyc + ((m == 0) ? i : 0));
        m_valid[m][i] = 1'b0;
        if (pat[m][i].size() > 0 && pat[m][i][0] == cyc) begin
          void'(pat[m][i].pop_front());
          if (mq[m][i].size() > 0) begin
            m_dout[m][i] = mq[m][i].pop_front();
            m_valid[m][i] = 1'b1;
          end else begin
            un = 1'b1;
          end
        end
        if (p[i]) begin
          if (mq[m][i].size() < DEPTH) mq[m][i].push_back(d[i*BW +: BW]);
          else ov = 1'b1;
        end
      end
      m_ovf[m] = (m_ovf[m] & ~c) | ov;
      m_unf[m] = (m_unf[m] & ~c) | un;
    end
    cyc++;
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      logic [NCH*BW-1:0] ed;
      logic [NCH*CW-1:0] ec;
      logic [NCH-1:0] ev, ee, ef, ea;
      string t;
      t = (m == 0) ? "skew" : "flat";
      for (int i = 0; i < NCH; i++) begin
        int sz;
        sz = mq[m][i].size();
        ed[i*BW +: BW] = m_dout[m][i];
        ev[i] = m_valid[m][i];
        ec[i*CW +: CW] = CW'(sz);
        ee[i] = (sz == 0);
        ef[i] = (sz == DEPTH);
        ea[i] = (sz >= DEPTH - 2);
      end
      chk({t, "_dout"}, 64'(dout[m]), 64'(ed));
      chk({t, "_valid"}, 64'(vout[m]), 64'(ev));
      chk({t, "_count"}, 64'(cnt[m]), 64'(ec));
      chk({t, "_empty"}, 64'(empty[m]), 64'(ee));
      chk({t, "_full"}, 64'(full[m]), 64'(ef));
      chk({t, "_afull"}, 64'(afull[m]), 64'(ea));
      chk({t, "_ovf"}, 64'(ovf[m]), 64'(m_ovf[m]));
      chk({t, "_unf"}, 64'(unf[m]), 64'(m_unf[m]));
    end
  endtask

  task automatic step(input logic [NCH-1:0] p, input logic [NCH*BW-1:0] d,
                      input logic po, input logic c);
    pushe = p;
    din = d;
    pope = po;
    clr = c;
    @(posedge CLK);
    #1;
    model_step(p, d, po, c);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    pushe = '0;
    din = '0;
    pope = 1'b0;
    clr = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
    check_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge CLK);
    #1;
    do_reset();
    chk("rst_empty", 64'(empty[0]), 64'hF);
    chk("rst_full", 64'(full[0]), 64'h0);
    chk("rst_afull", 64'(afull[0]), 64'h0);

    // Staggered wavefront: lane i delivers its byte i+1 cycles after POPE.
    step(4'hF, 32'h44332211, 1'b0, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    for (int k = 0; k < NCH; k++) begin
      logic [31:0] bytes;
      bytes = 32'h44332211;
      chk("w_valid", 64'(vout[0]), 64'(4'b0001 << k));
      chk("w_byte", 64'(dout[0][k*BW +: BW]), 64'(bytes[k*BW +: BW]));
      if (k < NCH - 1) idle(1);
    end
    idle(2);

    // Fill lane 0 past full, then drain it.
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      step(4'b0001, 32'(k), 1'b0, 1'b0);
      if (k == 1) chk("af_at1", 64'(afull[0][0]), 64'h0);
      if (k == 2) chk("af_at2", 64'(afull[0][0]), 64'h1);
    end
    chk("ovf_set", 64'(ovf[0]), 64'h1);
    chk("full_l0", 64'(full[0][0]), 64'h1);
    chk("cnt_l0", 64'(cnt[0][CW-1:0]), 64'd4);
    for (int k = 1; k <= 4; k++) begin
      step('0, '0, 1'b1, 1'b0);
      chk("drain_l0", 64'(dout[0][BW-1:0]), 64'(k));
    end
    idle(4);

    // Underflow on an empty bank, then clear.
    do_reset();
    step('0, '0, 1'b1, 1'b0);
    idle(4);
    chk("unf_set", 64'(unf[0]), 64'h1);
    step('0, '0, 1'b0, 1'b1);
    chk("unf_clr", 64'(unf[0]), 64'h0);

    // Push and pop together on a full lane.
    do_reset();
    for (int k = 1; k <= 4; k++) step(4'b0001, 32'(k), 1'b0, 1'b0);
    step(4'b0001, 32'hAA, 1'b1, 1'b0);
    chk("pp_cnt", 64'(cnt[0][CW-1:0]), 64'd4);
    chk("pp_old", 64'(dout[0][BW-1:0]), 64'h1);
    for (int k = 0; k < 4; k++) step('0, '0, 1'b1, 1'b0);
    chk("pp_new", 64'(dout[0][BW-1:0]), 64'hAA);
    idle(4);

    // Reset in the middle of a wavefront cancels the pending lanes.
    do_reset();
    step(4'hF, 32'h0D0C0B0A, 1'b0, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    idle(1);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      idle(1);
      chk("mid_rst_valid", 64'(vout[0]), 64'h0);
    end
    chk("mid_rst_cnt", 64'(cnt[0]), 64'h0);

    // Aligned instance pops every lane together.
    do_reset();
    step(4'hF, 32'h04030201, 1'b0, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    chk("flat_valid", 64'(vout[1]), 64'hF);
    idle(4);

    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step(4'($urandom), 32'($urandom), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 15) == 0));
      end
    end
    idle(6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
